// File: rtl/fp32_pkg.sv
// Shared fp32 constants and types for the wavelet datapath arithmetic blocks.
// The divider state enum lives here so checkers can bind to it by type.
package fp32_pkg;

  localparam int          EXP_W        = 8;
  localparam int          MANT_W       = 23;
  localparam int          FP32_BIAS    = 127;
  localparam int          FP32_EXP_MAX = 255;
  localparam logic [31:0] FP32_QNAN    = 32'h7FC00000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DIV   = 2'd1,
    ST_ROUND = 2'd2
  } div_state_e;

endpackage

// File: rtl/fp32_classify.sv
// Combinational zero/inf/NaN classification of one fp32 operand.
// An all-zero exponent field counts as zero, so denormals are flushed.
module fp32_classify
  import fp32_pkg::*;
(
  input  logic [EXP_W-1:0]  exp_f,
  input  logic [MANT_W-1:0] frac_f,
  output logic              is_zero,
  output logic              is_inf,
  output logic              is_nan
);

  always_comb begin
    is_zero = (exp_f == '0);
    is_inf  = (exp_f == '1) && (frac_f == '0);
    is_nan  = (exp_f == '1) && (frac_f != '0);
  end

endmodule

// File: rtl/fp32_div.sv
// Iterative fp32 divider: restoring division, one quotient bit per cycle,
// fixed 28-cycle latency, round to nearest even, one operation in flight.
//
// Handshake: an operand pair transfers on a rising edge where valid_din and
// ready are both 1; valid_din while ready is 0 is dropped silently. valid_out
// is a one-cycle pulse and result/dz_flag hold until the next completion.
module fp32_div
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dina,
  input  logic [31:0] dinb,
  input  logic        valid_din,
  output logic        ready,
  output logic [31:0] result,
  output logic        valid_out,
  output logic        dz_flag
);

  div_state_e state_q, state_d;

  logic [4:0]        cnt_q, cnt_d;
  logic [24:0]       rem_q, rem_d;
  logic [23:0]       dvs_q, dvs_d;
  logic [25:0]       quo_q, quo_d;
  logic signed [9:0] exp_q, exp_d;
  logic              sign_q, sign_d;
  logic              spec_q, spec_d;
  logic [31:0]       spec_res_q, spec_res_d;
  logic              spec_dz_q, spec_dz_d;
  logic [31:0]       result_q, result_d;
  logic              valid_out_q, valid_out_d;
  logic              dz_flag_q, dz_flag_d;

  logic a_zero, a_inf, a_nan;
  logic b_zero, b_inf, b_nan;

  logic              rem_ge;
  logic [23:0]       rem_sub;
  logic [22:0]       frac_n;
  logic              guard, sticky, rnd_up;
  logic [23:0]       frac_r;
  logic signed [9:0] exp_n, exp_r;
  logic [31:0]       packed_res;

  fp32_classify u_cls_a (
    .exp_f  (dina[30:23]),
    .frac_f (dina[22:0]),
    .is_zero(a_zero),
    .is_inf (a_inf),
    .is_nan (a_nan)
  );

  fp32_classify u_cls_b (
    .exp_f  (dinb[30:23]),
    .frac_f (dinb[22:0]),
    .is_zero(b_zero),
    .is_inf (b_inf),
    .is_nan (b_nan)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (valid_din) state_d = ST_DIV;
      ST_DIV:   if (cnt_q == 5'd0) state_d = ST_ROUND;
      ST_ROUND: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    ready     = (state_q == ST_IDLE);
    result    = result_q;
    valid_out = valid_out_q;
    dz_flag   = dz_flag_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q    <= '0;
      valid_out_q <= 1'b0;
      dz_flag_q   <= 1'b0;
    end else begin
      result_q    <= result_d;
      valid_out_q <= valid_out_d;
      dz_flag_q   <= dz_flag_d;
    end
  end

  always_ff @(posedge clk) begin
    cnt_q      <= cnt_d;
    rem_q      <= rem_d;
    dvs_q      <= dvs_d;
    quo_q      <= quo_d;
    exp_q      <= exp_d;
    sign_q     <= sign_d;
    spec_q     <= spec_d;
    spec_res_q <= spec_res_d;
    spec_dz_q  <= spec_dz_d;
  end

  // Normalise, round and pack from the finished quotient/remainder.
  // The quotient lies in (0.5, 2), so either q[25] or q[24] is the leading one.
  always_comb begin
    if (quo_q[25]) begin
      frac_n = quo_q[24:2];
      guard  = quo_q[1];
      sticky = quo_q[0] | (rem_q != '0);
      exp_n  = exp_q;
    end else begin
      frac_n = quo_q[23:1];
      guard  = quo_q[0];
      sticky = (rem_q != '0);
      exp_n  = exp_q - 10'sd1;
    end
    rnd_up = guard & (sticky | frac_n[0]);
    // A carry out of the fraction leaves frac_r[22:0] at zero, i.e. mantissa 1.0.
    frac_r = {1'b0, frac_n} + {23'd0, rnd_up};
    exp_r  = exp_n + 10'(frac_r[23]);
    if (int'(exp_r) >= FP32_EXP_MAX)
      packed_res = {sign_q, 8'hFF, 23'd0};
    else if (int'(exp_r) <= 0)
      packed_res = {sign_q, 31'd0};
    else
      packed_res = {sign_q, exp_r[7:0], frac_r[22:0]};
  end

  // Datapath: operand capture, restoring iteration, result registration.
  always_comb begin
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    quo_d       = quo_q;
    exp_d       = exp_q;
    sign_d      = sign_q;
    spec_d      = spec_q;
    spec_res_d  = spec_res_q;
    spec_dz_d   = spec_dz_q;
    result_d    = result_q;
    valid_out_d = 1'b0;
    dz_flag_d   = dz_flag_q;

    rem_ge  = (rem_q >= {1'b0, dvs_q});
    rem_sub = rem_ge ? 24'(rem_q - {1'b0, dvs_q}) : rem_q[23:0];

    case (state_q)
      ST_IDLE: begin
        if (valid_din) begin
          sign_d = dina[31] ^ dinb[31];
          exp_d  = 10'(int'(dina[30:23]) - int'(dinb[30:23]) + FP32_BIAS);
          rem_d  = {2'b01, dina[22:0]};
          dvs_d  = {1'b1, dinb[22:0]};
          quo_d  = '0;
          cnt_d  = 5'd25;
          spec_dz_d = 1'b0;
          if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
            spec_d     = 1'b1;
            spec_res_d = FP32_QNAN;
          end else if (a_inf || b_zero) begin
            spec_d     = 1'b1;
            spec_res_d = {dina[31] ^ dinb[31], 8'hFF, 23'd0};
            spec_dz_d  = b_zero && !a_inf;
          end else if (a_zero || b_inf) begin
            spec_d     = 1'b1;
            spec_res_d = {dina[31] ^ dinb[31], 31'd0};
          end else begin
            spec_d     = 1'b0;
            spec_res_d = '0;
          end
        end
      end
      ST_DIV: begin
        quo_d = {quo_q[24:0], rem_ge};
        rem_d = {rem_sub, 1'b0};
        if (cnt_q != 5'd0) cnt_d = cnt_q - 5'd1;
      end
      ST_ROUND: begin
        result_d    = spec_q ? spec_res_q : packed_res;
        dz_flag_d   = spec_q & spec_dz_q;
        valid_out_d = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
